seq_feeder_ctrl: RTL and testbench

Controller that sequences the serial sequence-detector datapath (`fsm_sequence`: `clock`, `reset`, `w` in, `z` out). On a start request it latches a bit pattern and length. It resets the detector, shifts the pattern out on `w` one bit per clock, MSB of the used field first, and counts cycles in which the detector reports `z` = 1. A done pulse and a saturating hit count are returned to the requester. It sits between the test/control logic and one `fsm_sequence` instance and replaces hand-written `w` stimulus.

---
 rtl/seq_feeder_ctrl.sv | 146 ++++++++++++++
 tb/tb_seq_feeder_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_feeder_ctrl.sv
// seq_feeder_ctrl: drives a serial sequence detector and counts its hits.
// Optional macro SEQ_FEEDER_LOOP_EN adds a `loop` input for repeated feeding.
module seq_feeder_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             z,
`ifdef SEQ_FEEDER_LOOP_EN
  input  logic             loop,
`endif
  output logic             w,
  output logic             det_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits,
  output logic             overflow
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] LMAX = LEN_W'(WIDTH);
  localparam logic [CNT_W-1:0] HMAX = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] sreg;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_c;
  logic [LEN_W-1:0] idx;
  logic             loop_go;
  logic             samp;

`ifdef SEQ_FEEDER_LOOP_EN
  assign loop_go = loop & (len_q != '0);
`else
  assign loop_go = 1'b0;
`endif

  // Clamp the requested length and decide when z is sampled
  always_comb begin
    len_c = (length > LMAX) ? LMAX : length;
    samp  = ((state == FEED) && (idx != '0))
          || (state == DRAIN);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and output decode
  always_comb begin
    state_n   = state;
    w         = 1'b0;
    det_reset = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = CLEAR;
      end
      CLEAR: begin
        det_reset = 1'b1;
        busy      = 1'b1;
        state_n   = (len_q == '0) ? DONE : FEED;
      end
      FEED: begin
        busy = 1'b1;
        w    = sreg[WIDTH-1];
        if (idx == len_q - LEN_W'(1))
          state_n = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = loop_go ? FEED : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pattern latch, MSB-first shifter and bit index
  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q <= '0;
      len_q <= '0;
      sreg  <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pat_q <= pattern;
            len_q <= len_c;
          end
        end
        CLEAR: begin
          idx  <= '0;
          sreg <= pat_q << (LMAX - len_q);
        end
        FEED: begin
          idx  <= idx + LEN_W'(1);
          sreg <= sreg << 1;
        end
        DONE: begin
          if (loop_go) begin
            idx  <= '0;
            sreg <= pat_q << (LMAX - len_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating hit counter with sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      hits     <= '0;
      overflow <= 1'b0;
    end else if (state == CLEAR) begin
      hits     <= '0;
      overflow <= 1'b0;
    end else if (samp && z) begin
      if (hits == HMAX) overflow <= 1'b1;
      else              hits     <= hits + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_feeder_ctrl.sv
// tb_seq_feeder_ctrl: directed bench with a one-cycle detector stub.
// Loop case is compiled in only with SEQ_FEEDER_LOOP_EN.
module tb_seq_feeder_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  length = '0;
  logic        z;
  logic        w, det_reset, busy, done;
  logic [7:0]  hits;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  // Detector stub: z is w delayed one cycle, cleared by det_reset
  always_ff @(posedge clock) begin
    if (reset || det_reset) z <= 1'b0;
    else                    z <= w;
  end

  seq_feeder_ctrl #(.WIDTH(16), .LEN_W(5), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .pattern(pattern), .length(length), .z(z),
`ifdef SEQ_FEEDER_LOOP_EN
    .loop(1'b0),
`endif
    .w(w), .det_reset(det_reset), .busy(busy),
    .done(done), .hits(hits), .overflow(overflow)
  );

`ifdef SEQ_FEEDER_LOOP_EN
  logic       start2 = 1'b0;
  logic       loop2 = 1'b0;
  logic       z2, w2, dr2, busy2, done2, ov2;
  logic [1:0] hits2;

  always_ff @(posedge clock) begin
    if (reset || dr2) z2 <= 1'b0;
    else              z2 <= w2;
  end

  seq_feeder_ctrl #(.WIDTH(16), .LEN_W(5), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .pattern(pattern), .length(length), .z(z2),
    .loop(loop2),
    .w(w2), .det_reset(dr2), .busy(busy2),
    .done(done2), .hits(hits2), .overflow(ov2)
  );
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic run(input string tag,
                     input logic [15:0] p,
                     input logic [4:0] l,
                     input int lat,
                     input logic [31:0] ew,
                     input logic [7:0] eh);
    int n;
    int drs;
    logic [31:0] obs;
    pattern = p;
    length  = l;
    start   = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    drs = 0;
    obs = '0;
    while (!done && n < 100) begin
      obs = {obs[30:0], w};
      drs += int'(det_reset);
      tick();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " w"}, obs, ew);
    check({tag, " det_reset"}, drs, 1);
    check({tag, " hits"}, {24'h0, hits}, {24'h0, eh});
    check({tag, " overflow"}, {31'h0, overflow}, 0);
    check({tag, " busy"}, {31'h0, busy}, 0);
  endtask

  initial begin
    int n;
    int drs;
    int sawdone;
    tick();
    tick();
    check("rst w", {31'h0, w}, 0);
    check("rst det_reset", {31'h0, det_reset}, 0);
    check("rst busy", {31'h0, busy}, 0);
    check("rst done", {31'h0, done}, 0);
    check("rst hits", {24'h0, hits}, 0);
    check("rst overflow", {31'h0, overflow}, 0);
    reset = 1'b0;
    tick();

    run("len4", 16'h000A, 5'd4, 7, 32'h14, 8'd2);
    tick();
    check("len4 hold hits", {24'h0, hits}, 2);
    check("len4 done pulse", {31'h0, done}, 0);

    run("clamp", 16'hFFFF, 5'd20, 19,
        32'h1FFFE, 8'd16);
    tick();
    run("len0", 16'hFFFF, 5'd0, 2, 32'h0, 8'd0);
    tick();

    pattern = 16'h0005;
    length  = 5'd3;
    start   = 1'b1;
    tick();
    n = 1;
    drs = 0;
    while (!done && n < 50) begin
      drs += int'(det_reset);
      tick();
      n++;
    end
    check("held latency", n, 6);
    check("held one clear", drs, 1);
    check("held hits", {24'h0, hits}, 2);
    tick();
    check("held idle busy", {31'h0, busy}, 0);
    check("held idle clr", {31'h0, det_reset}, 0);
    tick();
    check("held restart", {31'h0, det_reset}, 1);
    start = 1'b0;
    n = 1;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check("held2 latency", n, 6);
    check("held2 hits", {24'h0, hits}, 2);
    tick();

    pattern = 16'hFFFF;
    length  = 5'd16;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid hits nz", {31'h0, hits != 0}, 1);
    reset = 1'b1;
    tick();
    check("mid w", {31'h0, w}, 0);
    check("mid det_reset", {31'h0, det_reset}, 0);
    check("mid busy", {31'h0, busy}, 0);
    check("mid done", {31'h0, done}, 0);
    check("mid hits", {24'h0, hits}, 0);
    check("mid overflow", {31'h0, overflow}, 0);
    reset = 1'b0;
    sawdone = 0;
    for (int i = 0; i < 25; i++) begin
      sawdone += int'(done) + int'(busy);
      tick();
    end
    check("mid no done", sawdone, 0);

`ifdef SEQ_FEEDER_LOOP_EN
    pattern = 16'h0007;
    length  = 5'd3;
    loop2   = 1'b1;
    start2  = 1'b1;
    tick();
    start2 = 1'b0;
    sawdone = 0;
    n = 0;
    while (n < 200) begin
      if (done2) sawdone++;
      if (sawdone == 3) break;
      tick();
      n++;
      if (sawdone == 2) loop2 = 1'b0;
    end
    check("loop dones", sawdone, 3);
    check("loop hits", {30'h0, hits2}, 3);
    check("loop overflow", {31'h0, ov2}, 1);
    tick();
    check("loop idle", {30'h0, busy2, done2}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
